// File: rtl/alu_serial_ctrl.sv
// Serial ALU controller: runs a full-width add/sub/logic operation through a narrow external ALU, LSB slice first.
// Optional ALU_SERIAL_OVF_EN adds a signed Overflow output for add/sub.
module alu_serial_ctrl #(
   parameter int width = 4,
   parameter int words = 4
) (
   input  logic                   Clock,
   input  logic                   nReset,
   input  logic                   InValid,
   output logic                   InReady,
   input  logic [width*words-1:0] OperandA,
   input  logic [width*words-1:0] OperandB,
   input  logic [2:0]             Operation,
   input  logic                   CarryIn,
   output logic                   OutValid,
   input  logic                   OutReady,
   output logic [width*words-1:0] Result,
   output logic                   CarryOut,
`ifdef ALU_SERIAL_OVF_EN
   output logic                   Overflow,
`endif
   output logic [width-1:0]       AluA,
   output logic [width-1:0]       AluB,
   output logic [2:0]             AluOp,
   output logic                   AluCarryIn,
   input  logic [width-1:0]       AluAnswer,
   input  logic                   AluCarryOut
);

   localparam int TOTAL = width * words;
   localparam int IDX_W = (words > 1) ? $clog2(words) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(words - 1);

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic             chain;
   logic [TOTAL-1:0] a_cap;
   logic [TOTAL-1:0] b_cap;
   logic [2:0]       op_cap;
   logic             running;
   logic [width-1:0] slice_val;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   function automatic logic is_defined(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_XOR);
   endfunction

`ifdef ALU_SERIAL_OVF_EN
   logic ovf;

   // Subtraction is a + ~b, so B's sign is inverted before the same-sign test.
   function automatic logic signed_ovf(input logic [2:0] op, input logic a_sign,
                                       input logic b_sign, input logic r_sign);
      logic b_eff;
      b_eff = (op == OP_SUB) ? ~b_sign : b_sign;
      return is_arith(op) && (a_sign == b_eff) && (r_sign != a_sign);
   endfunction

   assign Overflow = ovf;
`endif

   assign running    = (state == RUN);
   assign InReady    = nReset && (state == IDLE);
   assign OutValid   = (state == DONE);
   assign slice_val  = is_defined(op_cap) ? AluAnswer : '0;

   assign AluA       = running ? a_cap[idx*width +: width] : '0;
   assign AluB       = running ? b_cap[idx*width +: width] : '0;
   assign AluOp      = running ? op_cap : 3'b000;
   assign AluCarryIn = running && is_arith(op_cap) && chain;

   // Request capture; the ALU-facing outputs are gated by state, so no reset is needed here.
   always_ff @(posedge Clock) begin
      if (state == IDLE && InValid) begin
         a_cap  <= OperandA;
         b_cap  <= OperandB;
         op_cap <= Operation;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state    <= IDLE;
         idx      <= '0;
         chain    <= 1'b0;
         Result   <= '0;
         CarryOut <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
         ovf      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (InValid) begin
                  state <= RUN;
                  idx   <= '0;
                  chain <= is_arith(Operation) ? CarryIn : 1'b0;
               end
            end
            RUN: begin
               Result[idx*width +: width] <= slice_val;
               idx   <= idx + 1'b1;
               chain <= is_arith(op_cap) ? AluCarryOut : 1'b0;
               if (idx == LAST_IDX) begin
                  state    <= DONE;
                  CarryOut <= is_arith(op_cap) ? AluCarryOut : 1'b0;
`ifdef ALU_SERIAL_OVF_EN
                  ovf      <= signed_ovf(op_cap, a_cap[TOTAL-1], b_cap[TOTAL-1],
                                         AluAnswer[width-1]);
`endif
               end
            end
            DONE: begin
               if (OutReady) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameters SHALL be: width, default 4, ALU slice width in bits; words, default 4, slices per operand (2..16).
REQ-002 Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 nReset  input  1  reset; asynchronous and active-low.
REQ-004 InValid  input  1  request valid.
REQ-005 InReady  output  1  controller can accept a request.
REQ-006 OperandA, OperandB  input  width*words each  full-width operands.
REQ-007 Operation  input  3  opcode: 001 add, 010 sub, 101 and, 110 or, 111 xor.
REQ-008 CarryIn  input  1  initial carry (add) or borrow (sub).
REQ-009 OutValid  output  1  result available.
REQ-010 OutReady  input  1  consumer accepts result.
REQ-011 Result  output  width*words  full-width result.
REQ-012 CarryOut  output  1  final carry (add) or borrow (sub).
REQ-013 AluA, AluB  output  width each  current slice operands to the ALU.
REQ-014 AluOp  output  3  opcode to the ALU; AluCarryIn  output  1  chained carry to the ALU.
REQ-015 AluAnswer  input  width; AluCarryOut  input  1  combinational ALU results.

Function
REQ-016 FSM SHALL have states IDLE, RUN, DONE; InReady SHALL be 1 only in IDLE.
REQ-017 IDLE: on InValid=1, SHALL capture OperandA, OperandB, Operation and CarryIn, clear slice index to 0, and go to RUN.
REQ-018 RUN: slices SHALL be processed LSB first, one per cycle; AluA/AluB SHALL be slice[index] of the captured operands, and AluOp SHALL be the captured opcode.
REQ-019 Each RUN edge SHALL write AluAnswer into Result slice[index] and increment index.
REQ-020 For add/sub, each RUN edge SHALL also load AluCarryOut into the chain register. AluCarryIn SHALL be that register, which starts at the captured CarryIn.
REQ-021 For logical and undefined opcodes (000, 011, 100), AluCarryIn SHALL be 0 and the chain register SHALL be forced to 0. Undefined opcodes SHALL produce Result 0 and CarryOut 0.
REQ-022 When index = words-1, the edge SHALL go to DONE. OutValid SHALL rise exactly words edges after the accepting edge.
REQ-023 DONE: Result, CarryOut and OutValid SHALL hold stable until the OutReady=1 edge, which SHALL return the FSM to IDLE.
REQ-024 No request SHALL be accepted on the cycle a result is consumed; minimum request spacing is words+2 cycles.
REQ-025 Outside RUN, AluA, AluB, AluOp and AluCarryIn SHALL be 0.
REQ-026 A request SHALL complete with the captured values even if the operand inputs change during RUN.

Reset
REQ-027 nReset=0 SHALL immediately set state IDLE, index 0, chain register 0, Result 0, CarryOut 0, OutValid 0 and all Alu* outputs 0, including mid-RUN (abort) and in DONE (result discarded).
REQ-028 InReady SHALL read 1 only once nReset is deasserted.

Configuration
REQ-029 With ALU_SERIAL_OVF_EN defined, an output Overflow (1 bit) SHALL exist. It SHALL be captured on the final RUN edge as signed overflow of add/sub: MSB-slice operand sign bits versus result sign bit, using B's sign inverted for sub. It SHALL be 0 for other opcodes and held like Result.
REQ-030 Without ALU_SERIAL_OVF_EN, Overflow and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Bench SHALL connect an instance of the team ALU (width=4, words=4) and cover these scenarios:
- add 0xFFFF + 0x0001, CarryIn 0 -> Result 0x0000, CarryOut 1, OutValid exactly 4 edges after accept.
- sub 0x0000 - 0x0001, CarryIn 0 -> Result 0xFFFF, CarryOut 1; sub 0x1234 - 0x0234, CarryIn 1 -> 0x0FFF, CarryOut 0.
- xor 0xA5A5 ^ 0x0FF0, CarryIn 1 -> Result 0xAA55, CarryOut 0, all AluCarryIn samples 0.
- OutReady held 0 for 3 cycles in DONE with InValid=1 -> Result/OutValid stable, InReady 0, no capture; request accepted only after return to IDLE.
- nReset pulsed low during the 2nd RUN slice -> all outputs 0 immediately; next add 0x0003 + 0x0004 -> 0x0007.
- ALU_SERIAL_OVF_EN: add 0x7FFF + 0x0001 -> 0x8000, Overflow 1; sub 0x8000 - 0x0001 -> 0x7FFF, Overflow 1; opcode 011 -> Result 0, Overflow 0.
